// File: rtl/matrix_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_keypad_ctrl
// Brief    : Row-scanned matrix keypad controller with scan-level debounce
//            and a keycode FIFO behind a two-register CPU read port.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_keypad_ctrl #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_SCANS = 21,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   rowwrite,
    input  logic [COLS-1:0]   colread,
    input  logic              a0,
    input  logic              rd_en,
    output logic [15:0]       dataout
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [7:0]       c_COLS8     = 8'(COLS);
    localparam logic [7:0]       c_DB_SCANS  = 8'(DEBOUNCE_SCANS);
    localparam logic [7:0]       c_FIFO_FULL = 8'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    // Scanner state
    logic [DIV_W-1:0] div_q, div_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROWS-1:0]  rowwrite_q, rowwrite_d;
    logic             scan_hit_q, scan_hit_d;
    logic [7:0]       scan_code_q, scan_code_d;

    // Debounce state
    logic [1:0]       state_q, state_d;
    logic [7:0]       db_cnt_q, db_cnt_d;
    logic [7:0]       db_code_q, db_code_d;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             w_step;
    logic             w_last_row;
    logic             w_row_hit;
    logic [COL_W-1:0] w_row_col;
    logic [7:0]       w_row_code;
    logic             w_scan_done;
    logic             w_scan_hit;
    logic [7:0]       w_scan_code;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_clr;
    logic             w_push_ok;
    logic             w_nonempty;
    logic             w_full;

    assign w_step     = (div_q == c_DIV_LAST);
    assign w_last_row = (row_q == c_ROW_LAST);

    // Lowest-indexed active-low column wins within the driven row.
    always_comb begin
        w_row_hit = 1'b0;
        w_row_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!colread[c]) begin
                w_row_hit = 1'b1;
                w_row_col = COL_W'(c);
            end
        end
    end

    assign w_row_code = 8'(row_q) * c_COLS8 + 8'(w_row_col);

    always_comb begin
        div_d       = div_q + 1'b1;
        row_d       = row_q;
        rowwrite_d  = rowwrite_q;
        scan_hit_d  = scan_hit_q;
        scan_code_d = scan_code_q;
        w_scan_done = 1'b0;
        w_scan_hit  = 1'b0;
        w_scan_code = scan_code_q;
        if (w_step) begin
            div_d      = '0;
            rowwrite_d = {rowwrite_q[ROWS-2:0], rowwrite_q[ROWS-1]};
            row_d      = w_last_row ? '0 : row_q + 1'b1;
            if (w_last_row) begin
                // The earliest detecting row of this scan takes precedence.
                w_scan_done = 1'b1;
                w_scan_hit  = scan_hit_q | w_row_hit;
                w_scan_code = scan_hit_q ? scan_code_q : w_row_code;
                scan_hit_d  = 1'b0;
                scan_code_d = '0;
            end else if (!scan_hit_q && w_row_hit) begin
                scan_hit_d  = 1'b1;
                scan_code_d = w_row_code;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        db_code_d = db_code_q;
        w_push    = 1'b0;
        if (w_scan_done) begin
            case (state_q)
                c_IDLE: begin
                    if (w_scan_hit) begin
                        state_d   = c_DEBOUNCE;
                        db_code_d = w_scan_code;
                        db_cnt_d  = 8'd1;
                    end
                end
                c_DEBOUNCE: begin
                    if (!w_scan_hit) begin
                        state_d  = c_IDLE;
                        db_cnt_d = 8'd0;
                    end else if (w_scan_code == db_code_q) begin
                        db_cnt_d = db_cnt_q + 8'd1;
                    end else begin
                        db_code_d = w_scan_code;
                        db_cnt_d  = 8'd1;
                    end
                end
                c_HELD: begin
                    if (!w_scan_hit) begin
                        state_d  = c_RELEASE;
                        db_cnt_d = 8'd1;
                    end
                end
                c_RELEASE: begin
                    if (w_scan_hit) begin
                        state_d  = c_HELD;
                        db_cnt_d = 8'd0;
                    end else begin
                        db_cnt_d = db_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d  = c_IDLE;
                    db_cnt_d = 8'd0;
                end
            endcase

            // Threshold applied to the updated count so a threshold of one accepts immediately.
            if (state_d == c_DEBOUNCE && db_cnt_d == c_DB_SCANS) begin
                state_d  = c_HELD;
                db_cnt_d = 8'd0;
                w_push   = 1'b1;
            end else if (state_d == c_RELEASE && db_cnt_d == c_DB_SCANS) begin
                state_d  = c_IDLE;
                db_cnt_d = 8'd0;
            end
        end
    end

    assign w_nonempty = (count_q != 8'd0);
    assign w_full     = (count_q == c_FIFO_FULL);
    assign w_pop      = rd_en && !a0 && w_nonempty;
    assign w_ovf_clr  = rd_en && a0;
    assign w_push_ok  = w_push && (!w_full || w_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = db_code_d;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else if (w_push) begin
            ovf_d = 1'b1;
        end
        if (w_push_ok && !w_pop) begin
            count_d = count_q + 8'd1;
        end else if (w_pop && !w_push_ok) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            row_q       <= '0;
            rowwrite_q  <= {{(ROWS-1){1'b1}}, 1'b0};
            scan_hit_q  <= 1'b0;
            scan_code_q <= '0;
            state_q     <= c_IDLE;
            db_cnt_q    <= 8'd0;
            db_code_q   <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 8'd0;
            ovf_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            rowwrite_q  <= rowwrite_d;
            scan_hit_q  <= scan_hit_d;
            scan_code_q <= scan_code_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            db_code_q   <= db_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage contents are only observed through count, so they need no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rowwrite = rowwrite_q;
    assign dataout  = a0         ? {count_q, 5'b00000, w_nonempty, w_full, ovf_q} :
                      w_nonempty ? {8'h00, mem_q[rd_ptr_q]} : 16'h00FF;

endmodule
`default_nettype wire
